// File: rtl/branch_predictor_bht_pkg.sv
// Shared sizing helpers, counter constants and sweep-FSM states for the branch history table.
package bp_pkg;

  typedef enum logic {BP_RUN, BP_CLEAR} bp_state_e;

  function automatic int unsigned idx_w(input int unsigned entries);
    return $clog2(entries);
  endfunction

  // Weakly not-taken: the value just below the MSB flip (0 for 1-bit counters).
  function automatic int unsigned ctr_wnt(input int unsigned bits);
    return (1 << (bits - 1)) - 1;
  endfunction

  function automatic int unsigned ctr_max(input int unsigned bits);
    return (1 << bits) - 1;
  endfunction

endpackage

// File: rtl/branch_predictor_bht_sat_counter.sv
// Saturating up/down counter with synchronous active-low reset and parallel load.
module sat_counter
  import bp_pkg::*;
#(
  parameter int unsigned W       = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX = W'(ctr_max(W));

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= load_val;
    end else if (inc) begin
      if (q != MAX) q <= q + 1'b1;
    end else if (dec) begin
      if (q != '0) q <= q - 1'b1;
    end
  end

endmodule

// File: rtl/branch_predictor_bht.sv
// Branch history table: PC(/gshare)-indexed saturating counters, clear sweep and mispredict stats.
module branch_predictor_bht
  import bp_pkg::*;
#(
  parameter int unsigned PC_WIDTH  = 32,
  parameter int unsigned ENTRIES   = 16,
  parameter int unsigned CTR_BITS  = 2,
  parameter int unsigned INDEX_LSB = 2,
  parameter int unsigned GHR_BITS  = 0,
  parameter int unsigned STAT_BITS = 16,
  localparam int unsigned IDX_W    = idx_w(ENTRIES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PC_WIDTH-1:0]  pc_f,
  output logic                 pred_taken_f,
  output logic [IDX_W-1:0]     pred_index_f,
  input  logic                 upd_valid_e,
  input  logic [IDX_W-1:0]     upd_index_e,
  input  logic                 upd_taken_e,
  input  logic                 upd_pred_e,
  output logic                 mispredict_e,
  input  logic                 clear_i,
  output logic                 busy,
  output logic [STAT_BITS-1:0] stat_branches,
  output logic [STAT_BITS-1:0] stat_mispredicts
);

  localparam logic [CTR_BITS-1:0] WNT = CTR_BITS'(ctr_wnt(CTR_BITS));

  bp_state_e         state, state_n;
  logic [IDX_W-1:0]  ptr, ptr_n;
  logic [IDX_W-1:0]  ghr_ext;
  logic              run;
  logic              upd_en;
  logic              unused_pc_bits;
  logic [CTR_BITS-1:0] table_q [ENTRIES];

  assign unused_pc_bits = ^pc_f;
  assign run          = (state == BP_RUN);
  // A clear request in the same cycle as an update discards the update.
  assign upd_en       = run && upd_valid_e && !clear_i;
  assign mispredict_e = upd_valid_e && (upd_taken_e != upd_pred_e);
  assign busy         = (state == BP_CLEAR);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= BP_RUN;
      ptr   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    case (state)
      BP_RUN: begin
        if (clear_i) begin
          state_n = BP_CLEAR;
          ptr_n   = '0;
        end
      end
      BP_CLEAR: begin
        ptr_n = ptr + 1'b1;
        if (ptr == IDX_W'(ENTRIES - 1)) state_n = BP_RUN;
      end
      default: state_n = BP_RUN;
    endcase
  end

  generate
    if (GHR_BITS > 0) begin : g_ghr
      logic [GHR_BITS-1:0] ghr;
      always_ff @(posedge clk) begin
        if (!reset) begin
          ghr <= '0;
        end else if (run && clear_i) begin
          ghr <= '0;
        end else if (upd_en) begin
          ghr <= GHR_BITS'({ghr, upd_taken_e});
        end
      end
      assign ghr_ext = IDX_W'(ghr);
    end else begin : g_no_ghr
      assign ghr_ext = '0;
    end
  endgenerate

  assign pred_index_f = pc_f[INDEX_LSB +: IDX_W] ^ ghr_ext;
  assign pred_taken_f = run && table_q[pred_index_f][CTR_BITS-1];

  generate
    for (genvar e = 0; e < ENTRIES; e++) begin : g_entry
      logic hit;
      assign hit = upd_en && (upd_index_e == IDX_W'(e));
      sat_counter #(.W(CTR_BITS), .RST_VAL(WNT)) u_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (busy && (ptr == IDX_W'(e))),
        .load_val (WNT),
        .inc      (hit && upd_taken_e),
        .dec      (hit && !upd_taken_e),
        .q        (table_q[e])
      );
    end
  endgenerate

  sat_counter #(.W(STAT_BITS), .RST_VAL('0)) u_stat_br (
    .clk      (clk),
    .reset    (reset),
    .load     (1'b0),
    .load_val ('0),
    .inc      (upd_en),
    .dec      (1'b0),
    .q        (stat_branches)
  );

  sat_counter #(.W(STAT_BITS), .RST_VAL('0)) u_stat_mp (
    .clk      (clk),
    .reset    (reset),
    .load     (1'b0),
    .load_val ('0),
    .inc      (upd_en && mispredict_e),
    .dec      (1'b0),
    .q        (stat_mispredicts)
  );

endmodule

// File: doc/branch_predictor_bht.md
Name: branch_predictor_bht

Overview:
- Parametrised branch history table (BHT) that replaces the single-state 1-bit branch FSM beside the conditional-execution logic.
- ENTRIES saturating counters of CTR_BITS each, indexed by fetch PC, optionally XORed with a global history register (gshare).
- Fetch stage reads a combinational prediction. Execute stage writes back the resolved outcome using the BranchTakenE-style signal.
- Adds a table-clear sweep FSM and saturating mispredict statistics.

Parameters:
- PC_WIDTH, 32, fetch PC width.
- ENTRIES, 16, table depth; power of two, at least 2. IDX_W = $clog2(ENTRIES).
- CTR_BITS, 2, counter width, 1..4. 1 gives legacy last-outcome behaviour.
- INDEX_LSB, 2, lowest PC bit used for the index (word-aligned instructions).
- GHR_BITS, 0, global history length, 0..IDX_W. 0 means pure bimodal.
- STAT_BITS, 16, width of the statistics counters.

Ports:
- clk, in, 1, clock; all state changes on the rising edge.
- reset, in, 1, synchronous, active-low; 0 at a rising edge resets the block.
- pc_f, in, PC_WIDTH, fetch PC.
- pred_taken_f, out, 1, predicted direction for pc_f.
- pred_index_f, out, IDX_W, index used; travels down the pipe with the branch.
- upd_valid_e, in, 1, a resolved conditional branch is in execute (Branch asserted).
- upd_index_e, in, IDX_W, pred_index_f carried to execute.
- upd_taken_e, in, 1, actual outcome (Branch & CondEx).
- upd_pred_e, in, 1, pred_taken_f carried to execute.
- mispredict_e, out, 1, combinational: upd_valid_e & (upd_taken_e != upd_pred_e).
- clear_i, in, 1, one-cycle request to re-initialise the table.
- busy, out, 1, clear sweep in progress.
- stat_branches, out, STAT_BITS, resolved branch count.
- stat_mispredicts, out, STAT_BITS, mispredict count.

Behaviour:
- Init value WNT = 2^(CTR_BITS-1)-1 (weakly not-taken). For CTR_BITS=1, WNT = 0.
- Prediction = counter MSB. The read is combinational with zero latency.
- Index = pc_f[INDEX_LSB +: IDX_W] XOR zero-extended ghr[GHR_BITS-1:0]. With GHR_BITS=0 the index is PC bits only.
- Update: when upd_valid_e and the FSM is in RUN, counter[upd_index_e] changes next edge.
  - Increments if taken, decrements if not.
  - Saturates at 2^CTR_BITS-1 and at 0; no wrap-around.
- GHR: non-speculative. On a valid update in RUN, ghr <= {ghr[GHR_BITS-2:0], upd_taken_e} next edge. GHR resets to 0.
- Same-index read and write in one cycle: the read returns the pre-update value. No bypass.
- Statistics:
  - stat_branches increments on each valid update in RUN.
  - stat_mispredicts increments when mispredict_e is also 1.
  - Both saturate at all-ones.
- The mispredict_e output itself is valid in every state.
- FSM states RUN and CLEAR:
  - Reset (reset==0 at an edge): all counters = WNT, ghr = 0, stats = 0, state = RUN, busy = 0, sweep pointer = 0. This takes effect in a single cycle.
  - RUN -> CLEAR: on clear_i. ptr <= 0, busy = 1 from the next cycle.
  - CLEAR: each cycle counter[ptr] <= WNT and ptr++. After writing entry ENTRIES-1, go to RUN (ENTRIES cycles total). ghr is cleared on entry to CLEAR.
  - In CLEAR: pred_taken_f forced to 0, updates ignored, stats frozen, clear_i ignored.
  - clear_i together with upd_valid_e in RUN: the update is discarded and the clear wins.
  - Reset during CLEAR aborts the sweep; the full reset applies.
- Reset values of outputs: pred_taken_f = 0 (WNT MSB), busy = 0, stats = 0. pred_index_f follows pc_f.

Decomposition:
- Package bp_pkg holds:
  - the function computing IDX_W;
  - the WNT/max constants as functions of CTR_BITS;
  - the state enum {BP_RUN, BP_CLEAR}.
- One sub-module, sat_counter (parametrised width): inc/dec/load with saturation. Used for table entries and, with load unused, for statistics.
- Table storage is a register array (flops, not RAM), because reset must initialise every entry in one cycle.

Test Plan:
- Reset then pc_f=0x100 -> pred_taken_f=0, pred_index_f=0 (ENTRIES=16, INDEX_LSB=2), stats 0.
- Two taken updates at index 5 (CTR_BITS=2): counter 1->2->3. Fetching the PC that maps to 5 predicts 1. A third taken update stays at 3. Three not-taken updates give 0, predict 0.
- Update index 7 taken with upd_pred_e=0 -> mispredict_e=1 the same cycle; stat_mispredicts=1, stat_branches=1. A pc_f that maps to 7 in the same cycle still reads the old value.
- GHR_BITS=2: updates taken, taken -> ghr=2'b11. pc_f index 4 -> pred_index_f=7.
- Train entries 0..15 to 3, pulse clear_i -> busy=1 for exactly 16 cycles with pred_taken_f=0. Updates during the sweep leave stats unchanged. Afterwards all entries predict 0.
- Assert reset=0 in cycle 5 of a sweep -> next cycle busy=0, all entries WNT. Preset stats to max-1, then two mispredicts -> stat_mispredicts holds at 0xFFFF.
